valu_operand_sequencer: RTL and testbench
=========================================

Name: valu_operand_sequencer

Overview:
- Per-instruction sequencer for vector-ALU operand A.
- Accepts one issued vector instruction via valid/ready and walks its element range in 64-bit beats.
- Source is scalar register, sign-extended immediate, VRF group or zero. Scalar/immediate are splatted per SEW.
- Sits between the vector issue stage and the VALU. Owns the VRF read port for operand A and presents a valid/ready beat stream with tail byte enables.

Parameters:
- VLEN, 512, vector register length in bits (multiple of 64); BEATS_PER_REG = VLEN/64.
- VL_W, 10, width of issue_vl; must hold VLEN.
- MAX_BEATS, 64, cap on beats per instruction (VLEN*8/64, i.e. LMUL=8).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- issue_valid  input  1  instruction offered
- issue_ready  output  1  high only in IDLE
- issue_src  input  2  00 scalar, 01 imm, 10 vector, 11 zero
- issue_sew  input  2  00 e8, 01 e16, 10 e32, 11 e64
- issue_vl  input  VL_W  element count
- issue_scalar  input  64  scalar operand (already sign-extended)
- issue_simm  input  64  sign-extended immediate
- issue_vs  input  5  base vector register
- vrf_rd_en  output  1  VRF read strobe
- vrf_rd_addr  output  5+log2(BEATS_PER_REG)  beat address
- vrf_rd_data  input  64  valid exactly one cycle after vrf_rd_en
- alu_valid  output  1  beat valid
- alu_ready  input  1  VALU accepts beat
- alu_dataA  output  64  operand A beat
- alu_be  output  8  byte enables
- alu_last  output  1  final beat of instruction
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except issue_ready=1; counters, skid buffer and in-flight flag cleared.
- Reset mid-instruction: abandons the instruction immediately; no done pulse.
- Handshake:
  - Issue fires on issue_valid & issue_ready; all issue_* fields are captured.
  - An ALU beat transfers on alu_valid & alu_ready.
  - While alu_valid=1 and alu_ready=0, alu_dataA/alu_be/alu_last are held stable.
- Beat math:
  - bytes = issue_vl << issue_sew.
  - beats = min(ceil(bytes/8), MAX_BEATS).
  - rem = bytes mod 8.
  - alu_be = 8'hFF, except on the last beat with rem != 0, where alu_be = (1<<rem)-1.
- Splat:
  - e8: scalar[7:0] replicated 8x; e16: [15:0] 4x; e32: [31:0] 2x; e64: as-is.
  - Same rule for the immediate. Zero source gives 64'b0.
- States:
  - IDLE: on issue, if beats==0 go to DONE; else go to RUN.
  - RUN, scalar/imm/zero source:
    - Beat presented the cycle after entry.
    - One beat per cycle while alu_ready=1.
    - After the last beat transfers, go to DONE.
  - RUN, vector source:
    - vrf_rd_addr = (issue_vs*BEATS_PER_REG + beat_idx) mod (32*BEATS_PER_REG).
    - Credit scheme: output register + 1-entry skid buffer = 2 credits.
    - A read issues when (occupied + in-flight) < 2 and reads remain.
    - Returned data goes into the output register if it is free or draining this cycle; otherwise into the skid buffer.
    - Full throughput is 1 beat/cycle with alu_ready held high; first beat valid 2 cycles after issue.
    - Once all reads are issued and the final beat transfers, go to DONE.
  - DONE: done=1 for one cycle; next state IDLE (issue_ready=1 again next cycle).
- Simultaneous events:
  - Transfer and read-return in the same cycle: the skid entry (if any) advances to the output register, and new data lands behind it.
  - No beat is ever dropped or duplicated.
- alu_last=1 only on the beat whose index is beats-1.

Optional Feature:
- Macro: VALU_SEQ_PERF_EN.
- With the macro: adds outputs perf_busy_cnt[31:0] (cycles with busy=1) and perf_stall_cnt[31:0] (cycles with alu_valid & !alu_ready).
  - Both are saturating and reset to 0.
  - Both clear on a new issue handshake only if input perf_clr=1.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include (vector constants header) holds:
  - src encodings (VSRC_SCALAR, VSRC_IMM, VSRC_VEC, VSRC_ZERO);
  - SEW encodings;
  - state encodings (IDLE/RUN/DONE).
- One natural sub-module: valu_splat64, the combinational SEW replicator (sew, value → 64-bit splat).
- Skid buffer and credit logic stay inline.

Test Plan:
- Scalar e8, vl=11, scalar=0x..A5, alu_ready=1:
  - 2 beats, both data 0xA5A5A5A5A5A5A5A5.
  - be FF then 07; alu_last on beat 1; done 1 cycle later.
- Imm e32, vl=3, simm=0xFFFFFFFFFFFFFFFE, alu_ready toggling 1/0:
  - 2 beats, 0xFFFFFFFEFFFFFFFE each; be FF then 0F.
  - Outputs stable while stalled.
- Vector e64, vs=31, vl=10, VLEN=512:
  - Reads at addresses 248..255 then 0,1 (wrap).
  - 10 beats back-to-back with ready=1; first alu_valid 2 cycles after issue.
- Vector e16, vl=16, alu_ready low 5 cycles after first beat:
  - Never more than 2 reads outstanding/buffered.
  - All 4 beats delivered in address order.
- vl=0 any source: no alu_valid and no vrf_rd_en; done pulses the cycle after issue.
- rst_n asserted mid-RUN (vector, beat 3 of 8):
  - All outputs clear asynchronously; no done.
  - A new issue after release sequences correctly from beat 0.

Source files
------------

// File: rtl/valu_operand_sequencer_pkg.sv
// Shared encodings for the VALU operand-A sequencer: source select, SEW, FSM states,
// and the tail byte-enable helper.
package valu_operand_sequencer_pkg;

  localparam logic [1:0] VSRC_SCALAR = 2'b00;
  localparam logic [1:0] VSRC_IMM    = 2'b01;
  localparam logic [1:0] VSRC_VEC    = 2'b10;
  localparam logic [1:0] VSRC_ZERO   = 2'b11;

  localparam logic [1:0] SEW_E8  = 2'b00;
  localparam logic [1:0] SEW_E16 = 2'b01;
  localparam logic [1:0] SEW_E32 = 2'b10;
  localparam logic [1:0] SEW_E64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  // Only the final beat of a partial 8-byte group gets a reduced mask.
  function automatic logic [7:0] tail_be(input logic [2:0] rem, input logic is_last);
    if (is_last && (rem != 3'd0)) return 8'hFF >> (4'd8 - {1'b0, rem});
    return 8'hFF;
  endfunction

endpackage

// File: rtl/valu_operand_sequencer_splat64.sv
// valu_splat64: replicates the low SEW-sized element of a 64-bit value across a full beat.
module valu_splat64
  import valu_operand_sequencer_pkg::*;
(
  input  logic [1:0]  sew_i,
  input  logic [63:0] value_i,
  output logic [63:0] splat_o
);

  always_comb begin
    splat_o = value_i;
    case (sew_i)
      SEW_E8:  splat_o = {8{value_i[7:0]}};
      SEW_E16: splat_o = {4{value_i[15:0]}};
      SEW_E32: splat_o = {2{value_i[31:0]}};
      default: splat_o = value_i;
    endcase
  end

endmodule

// File: rtl/valu_operand_sequencer.sv
// Operand-A sequencer: walks one vector instruction's element range as 64-bit beats.
// Optional perf counters (busy / stall cycles) are built when VALU_SEQ_PERF_EN is defined.
module valu_operand_sequencer
  import valu_operand_sequencer_pkg::*;
#(
  parameter int VLEN      = 512,
  parameter int VL_W      = 10,
  parameter int MAX_BEATS = 64,
  localparam int BEATS_PER_REG = VLEN / 64,
  localparam int ADDR_W        = 5 + $clog2(BEATS_PER_REG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_src,
  input  logic [1:0]        issue_sew,
  input  logic [VL_W-1:0]   issue_vl,
  input  logic [63:0]       issue_scalar,
  input  logic [63:0]       issue_simm,
  input  logic [4:0]        issue_vs,
  output logic              vrf_rd_en,
  output logic [ADDR_W-1:0] vrf_rd_addr,
  input  logic [63:0]       vrf_rd_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [63:0]       alu_dataA,
  output logic [7:0]        alu_be,
  output logic              alu_last,
  output logic              busy,
  output logic              done
`ifdef VALU_SEQ_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_busy_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int BCNT_W = $clog2(MAX_BEATS + 1);
  localparam int SH_W   = $clog2(BEATS_PER_REG);

  seq_state_e        state_q;
  logic [1:0]        src_q;
  logic [4:0]        vs_q;
  logic [BCNT_W-1:0] beats_q, idx_q;
  logic [2:0]        rem_q;
  logic [63:0]       splat_q;
  logic              infl_q;
  logic              out_v_q, out_last_q, skid_v_q, skid_last_q;
  logic [63:0]       out_data_q, skid_data_q;
  logic [7:0]        out_be_q, skid_be_q;

  // Issue-time beat math.
  logic [VL_W+2:0]   iss_bytes;
  logic [VL_W:0]     iss_beats_raw;
  logic [BCNT_W-1:0] iss_beats;
  logic [2:0]        iss_rem;
  logic              iss_fire;
  logic [63:0]       splat_in, splat_out, splat_val;

  assign iss_bytes     = {3'b000, issue_vl} << issue_sew;
  assign iss_beats_raw = {1'b0, iss_bytes[VL_W+2:3]} + (VL_W+1)'(|iss_bytes[2:0]);
  assign iss_beats     = (iss_beats_raw > (VL_W+1)'(MAX_BEATS)) ? BCNT_W'(MAX_BEATS)
                                                                : BCNT_W'(iss_beats_raw);
  assign iss_rem       = iss_bytes[2:0];
  assign iss_fire      = issue_valid && (state_q == ST_IDLE);

  assign splat_in  = (issue_src == VSRC_IMM) ? issue_simm : issue_scalar;
  assign splat_val = (issue_src == VSRC_ZERO) ? 64'd0 : splat_out;

  valu_splat64 u_splat (
    .sew_i   (issue_sew),
    .value_i (splat_in),
    .splat_o (splat_out)
  );

  // Credits: output register + skid entry; a beat draining this cycle frees its slot.
  logic       xfer, run_rd, iss_rd;
  logic [1:0] used;
  logic       gen_last, ret_last;
  logic [7:0] ret_be;

  assign xfer     = out_v_q && alu_ready;
  assign used     = 2'(out_v_q) + 2'(skid_v_q) + 2'(infl_q) - 2'(xfer);
  assign run_rd   = (state_q == ST_RUN) && (src_q == VSRC_VEC) && (idx_q < beats_q) && (used < 2'd2);
  assign iss_rd   = iss_fire && (issue_src == VSRC_VEC) && (iss_beats != '0);
  assign gen_last = (idx_q == beats_q - BCNT_W'(1));
  assign ret_last = (idx_q == beats_q);
  assign ret_be   = tail_be(rem_q, ret_last);

  assign vrf_rd_en   = run_rd || iss_rd;
  assign vrf_rd_addr = iss_rd ? (ADDR_W'(issue_vs) << SH_W) :
                       run_rd ? ((ADDR_W'(vs_q) << SH_W) + ADDR_W'(idx_q)) : '0;

  assign issue_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign alu_valid   = out_v_q;
  assign alu_dataA   = out_data_q;
  assign alu_be      = out_be_q;
  assign alu_last    = out_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_q       <= VSRC_SCALAR;
      vs_q        <= '0;
      beats_q     <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      splat_q     <= '0;
      infl_q      <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_last_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_be_q   <= '0;
      skid_last_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_valid) begin
            src_q   <= issue_src;
            vs_q    <= issue_vs;
            beats_q <= iss_beats;
            rem_q   <= iss_rem;
            splat_q <= splat_val;
            idx_q   <= '0;
            infl_q  <= 1'b0;
            if (iss_beats == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
              idx_q   <= BCNT_W'(1);
              if (issue_src == VSRC_VEC) begin
                infl_q <= 1'b1;
              end else begin
                out_v_q    <= 1'b1;
                out_data_q <= splat_val;
                out_be_q   <= tail_be(iss_rem, iss_beats == BCNT_W'(1));
                out_last_q <= (iss_beats == BCNT_W'(1));
              end
            end
          end
        end
        ST_RUN: begin
          infl_q <= run_rd;
          if (src_q == VSRC_VEC) begin
            if (run_rd) idx_q <= idx_q + BCNT_W'(1);
            if (xfer) begin
              if (skid_v_q) begin
                out_data_q <= skid_data_q;
                out_be_q   <= skid_be_q;
                out_last_q <= skid_last_q;
                skid_v_q   <= infl_q;
                if (infl_q) begin
                  skid_data_q <= vrf_rd_data;
                  skid_be_q   <= ret_be;
                  skid_last_q <= ret_last;
                end
              end else if (infl_q) begin
                out_data_q <= vrf_rd_data;
                out_be_q   <= ret_be;
                out_last_q <= ret_last;
              end else begin
                out_v_q <= 1'b0;
              end
            end else if (infl_q) begin
              if (!out_v_q) begin
                out_v_q    <= 1'b1;
                out_data_q <= vrf_rd_data;
                out_be_q   <= ret_be;
                out_last_q <= ret_last;
              end else begin
                skid_v_q    <= 1'b1;
                skid_data_q <= vrf_rd_data;
                skid_be_q   <= ret_be;
                skid_last_q <= ret_last;
              end
            end
          end else if (xfer) begin
            if (out_last_q) begin
              out_v_q <= 1'b0;
            end else begin
              out_data_q <= splat_q;
              out_be_q   <= tail_be(rem_q, gen_last);
              out_last_q <= gen_last;
              idx_q      <= idx_q + BCNT_W'(1);
            end
          end
          if (xfer && out_last_q) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef VALU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else if (iss_fire && perf_clr) begin
      perf_busy_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (busy && (perf_busy_cnt != '1)) perf_busy_cnt <= perf_busy_cnt + 32'd1;
      if (out_v_q && !alu_ready && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_valu_operand_sequencer.sv
// Directed table-driven bench for valu_operand_sequencer with a simple VRF memory model.
module tb_valu_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_src;
  logic [1:0]  issue_sew;
  logic [9:0]  issue_vl;
  logic [63:0] issue_scalar;
  logic [63:0] issue_simm;
  logic [4:0]  issue_vs;
  logic        vrf_rd_en;
  logic [7:0]  vrf_rd_addr;
  logic [63:0] vrf_rd_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [63:0] alu_dataA;
  logic [7:0]  alu_be;
  logic        alu_last;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  addr_q[$];

  typedef struct {
    logic [1:0]  src;
    logic [1:0]  sew;
    logic [9:0]  vl;
    logic [63:0] scalar;
    logic [63:0] simm;
    logic [4:0]  vs;
    int          ready_mode;   // 0 always ready, 1 toggle, 2 five-cycle stall after first beat
    int          exp_beats;
    logic [63:0] exp_data;     // splat value for non-vector sources
    logic [7:0]  exp_be_last;
    int          exp_lat;      // cycle of first alu_valid after issue cycle, -1 if none
    int          exp_done;     // cycle of the done pulse after issue cycle
    logic [7:0]  exp_addr0;    // first VRF address for vector sources
  } vec_t;

  localparam int N = 11;
  vec_t tbl[N];
  vec_t t_ab;

  valu_operand_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_src    (issue_src),
    .issue_sew    (issue_sew),
    .issue_vl     (issue_vl),
    .issue_scalar (issue_scalar),
    .issue_simm   (issue_simm),
    .issue_vs     (issue_vs),
    .vrf_rd_en    (vrf_rd_en),
    .vrf_rd_addr  (vrf_rd_addr),
    .vrf_rd_data  (vrf_rd_data),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_dataA    (alu_dataA),
    .alu_be       (alu_be),
    .alu_last     (alu_last),
    .busy         (busy),
    .done         (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_fn(input logic [7:0] a);
    return {8{a}} ^ 64'h0F1E_2D3C_4B5A_6978;
  endfunction

  // VRF: data appears exactly one cycle after the read strobe.
  always @(posedge clk) vrf_rd_data <= vrf_rd_en ? mem_fn(vrf_rd_addr) : 64'hDEAD_DEAD_DEAD_DEAD;

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_fn(input int mode, input int cyc, input int first_cyc);
    if (mode == 1) return cyc[0];
    if (mode == 2) return !(first_cyc >= 0 && cyc > first_cyc && cyc <= first_cyc + 5);
    return 1'b1;
  endfunction

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_src    = 2'b00;
    issue_sew    = 2'b00;
    issue_vl     = '0;
    issue_scalar = '0;
    issue_simm   = '0;
    issue_vs     = '0;
    alu_ready    = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic run_instr(input vec_t t, input int abort_after);
    int   beat = 0;
    int   reads = 0;
    int   first_cyc = -1;
    int   done_cyc = -1;
    logic stop = 1'b0;
    logic is_vec = (t.src == 2'b10);
    logic [7:0] a;
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < t.exp_beats; k++) begin
      a = t.exp_addr0 + 8'(k);
      if (is_vec) begin
        addr_q.push_back(a);
        exp_q.push_back(mem_fn(a));
      end else begin
        exp_q.push_back(t.exp_data);
      end
    end

    @(negedge clk);
    issue_valid  = 1'b1;
    issue_src    = t.src;
    issue_sew    = t.sew;
    issue_vl     = t.vl;
    issue_scalar = t.scalar;
    issue_simm   = t.simm;
    issue_vs     = t.vs;

    for (int cyc = 0; cyc < 300 && !stop; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        issue_valid = 1'b0;
      end
      alu_ready = ready_fn(t.ready_mode, cyc, first_cyc);
      #1;
      if (cyc == 0) begin
        chk("issue_ready_at_issue", 64'(issue_ready), 64'd1);
        chk("busy_at_issue", 64'(busy), 64'd0);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("ready_after_done", 64'(issue_ready), 64'd1);
        stop = 1'b1;
      end else begin
        if (vrf_rd_en) begin
          reads++;
          if (addr_q.size() > 0) chk("rd_addr", 64'(vrf_rd_addr), 64'(addr_q.pop_front()));
          else chk("unexpected_read", 64'(vrf_rd_addr), 64'hFFFF);
        end
        if (alu_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", alu_dataA, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk("alu_dataA", alu_dataA, exp_q[0]);
            chk("alu_be", 64'(alu_be), (beat == t.exp_beats - 1) ? 64'(t.exp_be_last) : 64'hFF);
            chk("alu_last", 64'(alu_last), 64'(beat == t.exp_beats - 1));
            if (alu_ready) begin
              void'(exp_q.pop_front());
              beat++;
            end
          end
        end
        if (is_vec) chk("credits_le_2", 64'(reads - beat <= 2), 64'd1);
        if (done) begin
          chk("busy_in_done", 64'(busy), 64'd1);
          done_cyc = cyc;
        end
        if (abort_after >= 0 && beat == abort_after) begin
          @(negedge clk);
          rst_n = 1'b0;
          #1;
          chk("rst_alu_valid", 64'(alu_valid), 64'd0);
          chk("rst_alu_data", alu_dataA, 64'd0);
          chk("rst_alu_be_last", {55'd0, alu_be, alu_last}, 64'd0);
          chk("rst_vrf_rd_en", 64'(vrf_rd_en), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_issue_ready", 64'(issue_ready), 64'd1);
          idle_inputs();
          for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("rst_no_done", 64'(done), 64'd0);
          end
          rst_n = 1'b1;
          @(negedge clk);
          chk("post_rst_no_done", 64'(done), 64'd0);
          return;
        end
      end
    end

    chk("done_cycle", 64'(done_cyc), 64'(t.exp_done));
    chk("beat_count", 64'(beat), 64'(t.exp_beats));
    chk("first_valid_latency", 64'(first_cyc), 64'(t.exp_lat));
    chk("read_count", 64'(reads), is_vec ? 64'(t.exp_beats) : 64'd0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    idle_inputs();
  endtask

  // ---------------- test ----------------
  initial begin
    //         src    sew    vl      scalar                  simm                    vs     rm beats data                    be_last lat done addr0
    tbl[0]  = '{2'b00, 2'b00, 10'd11,  64'h0123_4567_89AB_CDA5, 64'h0,                  5'd0,  0, 2,  64'hA5A5_A5A5_A5A5_A5A5, 8'h07, 1,  3,  8'd0};
    tbl[1]  = '{2'b01, 2'b10, 10'd3,   64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0,  1, 2,  64'hFFFF_FFFE_FFFF_FFFE, 8'h0F, 1,  4,  8'd0};
    tbl[2]  = '{2'b10, 2'b11, 10'd10,  64'h0,                  64'h0,                  5'd31, 0, 10, 64'h0,                  8'hFF, 2,  12, 8'd248};
    tbl[3]  = '{2'b10, 2'b01, 10'd16,  64'h0,                  64'h0,                  5'd5,  2, 4,  64'h0,                  8'hFF, 2,  11, 8'd40};
    tbl[4]  = '{2'b00, 2'b00, 10'd0,   64'h0000_0000_0000_0077, 64'h0,                  5'd0,  0, 0,  64'h0,                  8'hFF, -1, 1,  8'd0};
    tbl[5]  = '{2'b10, 2'b11, 10'd0,   64'h0,                  64'h0,                  5'd3,  0, 0,  64'h0,                  8'hFF, -1, 1,  8'd24};
    tbl[6]  = '{2'b11, 2'b01, 10'd5,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  0, 2,  64'h0,                  8'h03, 1,  3,  8'd0};
    tbl[7]  = '{2'b00, 2'b01, 10'd4,   64'h0000_0000_1234_BEEF, 64'h0,                  5'd0,  0, 1,  64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, 1,  2,  8'd0};
    tbl[8]  = '{2'b00, 2'b11, 10'd100, 64'h8000_0000_0000_0001, 64'h0,                  5'd0,  0, 64, 64'h8000_0000_0000_0001, 8'hFF, 1,  65, 8'd0};
    tbl[9]  = '{2'b01, 2'b00, 10'd1,   64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 5'd0,  0, 1,  64'h8080_8080_8080_8080, 8'h01, 1,  2,  8'd0};
    tbl[10] = '{2'b10, 2'b00, 10'd13,  64'h0,                  64'h0,                  5'd0,  0, 2,  64'h0,                  8'h1F, 2,  4,  8'd0};
    t_ab    = '{2'b10, 2'b11, 10'd8,   64'h0,                  64'h0,                  5'd2,  0, 8,  64'h0,                  8'hFF, 2,  10, 8'd16};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("reset_issue_ready", 64'(issue_ready), 64'd1);
    chk("reset_alu_valid", 64'(alu_valid), 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset_vrf_rd_en", 64'(vrf_rd_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) run_instr(tbl[i], -1);
    run_instr(t_ab, 3);
    run_instr(t_ab, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
